// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory read,
// buffers one instruction across downstream stalls and counts deliveries.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic [31:0]      iload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic [31:0]      instr,
    output logic [31:0]      npc,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_instr, hold_next;
    logic        count_inc;

    assign iaddr = pc;
    assign npc   = pc + 32'd4;

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        hold_next  = hold_instr;
        count_inc  = 1'b0;
        iREN       = 1'b0;
        instr      = iload;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;

        case (state)
            FETCH: begin
                iREN = 1'b1;
                if (ihit && !stall) begin
                    ifid_en   = 1'b1;
                    pc_next   = pc + 32'd4;
                    count_inc = 1'b1;
                end else if (ihit && stall) begin
                    hold_next  = iload;
                    state_next = HOLD;
                end else if (!stall) begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end
            end
            HOLD: begin
                instr = hold_instr;
                if (!stall) begin
                    ifid_en    = 1'b1;
                    pc_next    = pc + 32'd4;
                    count_inc  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: ;
        endcase

        // Halt and redirect override whatever the normal fetch/hold path chose.
        if (state != HALTED) begin
            if (halt) begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                pc_next    = pc;
                hold_next  = hold_instr;
                count_inc  = 1'b0;
                state_next = HALTED;
            end else if (redirect) begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                pc_next    = {redirect_pc[31:2], 2'b00};
                hold_next  = hold_instr;
                count_inc  = 1'b0;
                state_next = FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            hold_instr  <= '0;
            fetch_count <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_instr <= hold_next;
            if (count_inc) fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: two instances (default and wrap-corner
// parameters) share stimulus and are checked against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST, ihit, stall, redirect, halt;
    logic [31:0] iload, redirect_pc;

    logic        iren_a, en_a, flush_a;
    logic [31:0] iaddr_a, instr_a, npc_a, cnt_a;
    logic        iren_b, en_b, flush_b;
    logic [31:0] iaddr_b, instr_b, npc_b;
    logic [3:0]  cnt_b;

    fetch_unit dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iren_a),
        .iaddr(iaddr_a), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .instr(instr_a), .npc(npc_a), .ifid_en(en_a),
        .ifid_flush(flush_a), .fetch_count(cnt_a)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC), .CNT_W(4)) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iren_b),
        .iaddr(iaddr_b), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .instr(instr_b), .npc(npc_b), .ifid_en(en_b),
        .ifid_flush(flush_b), .fetch_count(cnt_b)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: per instance, the PC, the delivered count, whether an instruction
    // is parked waiting for the stall to clear, and whether fetch has stopped.
    logic [31:0] m_pc[2], m_cnt[2], m_held[2];
    bit          m_holding[2], m_halted[2];
    logic [31:0] m_init[2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    logic [31:0] m_mask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]      = m_init[i];
            m_cnt[i]     = 0;
            m_held[i]    = 0;
            m_holding[i] = 0;
            m_halted[i]  = 0;
        end
    endtask

    task automatic model_step(input int i);
        if (m_halted[i]) return;
        if (halt) begin
            m_halted[i] = 1;
        end else if (redirect) begin
            m_pc[i]      = redirect_pc & 32'hFFFF_FFFC;
            m_holding[i] = 0;
        end else if (m_holding[i]) begin
            if (!stall) begin
                m_pc[i]      = m_pc[i] + 4;
                m_cnt[i]     = (m_cnt[i] + 1) & m_mask[i];
                m_holding[i] = 0;
            end
        end else if (ihit && !stall) begin
            m_pc[i]  = m_pc[i] + 4;
            m_cnt[i] = (m_cnt[i] + 1) & m_mask[i];
        end else if (ihit && stall) begin
            m_held[i]    = iload;
            m_holding[i] = 1;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic        e_iren, e_en, e_flush;
            logic        o_iren, o_en, o_flush;
            logic [31:0] o_iaddr, o_instr, o_npc, o_cnt;
            if (i == 0) begin
                o_iren = iren_a; o_en = en_a; o_flush = flush_a;
                o_iaddr = iaddr_a; o_instr = instr_a; o_npc = npc_a; o_cnt = cnt_a;
            end else begin
                o_iren = iren_b; o_en = en_b; o_flush = flush_b;
                o_iaddr = iaddr_b; o_instr = instr_b; o_npc = npc_b; o_cnt = {28'b0, cnt_b};
            end
            e_iren = !m_halted[i] && !m_holding[i];
            if (m_halted[i])            begin e_en = 0; e_flush = 0; end
            else if (halt || redirect)  begin e_en = 1; e_flush = 1; end
            else if (m_holding[i])      begin e_en = !stall; e_flush = 0; end
            else if (stall)             begin e_en = 0; e_flush = 0; end
            else                        begin e_en = 1; e_flush = !ihit; end
            check($sformatf("iren[%0d]", i), {31'b0, o_iren}, {31'b0, e_iren});
            check($sformatf("iaddr[%0d]", i), o_iaddr, m_pc[i]);
            check($sformatf("npc[%0d]", i), o_npc, m_pc[i] + 32'd4);
            check($sformatf("ifid_en[%0d]", i), {31'b0, o_en}, {31'b0, e_en});
            check($sformatf("count[%0d]", i), o_cnt, m_cnt[i]);
            if (e_en)
                check($sformatf("flush[%0d]", i), {31'b0, o_flush}, {31'b0, e_flush});
            if (!m_halted[i])
                check($sformatf("instr[%0d]", i), o_instr, m_holding[i] ? m_held[i] : iload);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check settled outputs,
    // then advance the model to match the coming rising edge.
    task automatic cyc(input bit rst, input bit h, input logic [31:0] ld, input bit st,
                       input bit rd, input logic [31:0] rp, input bit hl);
        @(negedge CLK);
        nRST = rst; ihit = h; iload = ld; stall = st;
        redirect = rd; redirect_pc = rp; halt = hl;
        #1;
        if (!rst) model_reset();
        compare_all();
        if (rst) begin
            model_step(0);
            model_step(1);
        end
    endtask

    initial begin
        nRST = 0; ihit = 0; iload = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        model_reset();
        cyc(0, 1, 32'h1111_1111, 0, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0, 0);

        // Straight-line fetch of three instructions.
        cyc(1, 1, 32'h2001_0001, 0, 0, 0, 0);
        cyc(1, 1, 32'h2002_0002, 0, 0, 0, 0);
        cyc(1, 1, 32'h2003_0003, 0, 0, 0, 0);
        @(posedge CLK); #1;
        check("seq_count", cnt_a, 32'd3);
        check("seq_iaddr", iaddr_a, 32'hC);

        // Hit under stall parks the word; it is delivered when the stall clears.
        cyc(1, 0, 0, 0, 1, 32'h40, 0);
        cyc(1, 1, 32'h8C22_0000, 1, 0, 0, 0);
        cyc(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
        cyc(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0, 0);
        check("hold_instr", instr_a, 32'h8C22_0000);
        check("hold_npc", npc_a, 32'h44);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("after_hold_iaddr", iaddr_a, 32'h44);

        // Misses produce bubbles without moving the PC.
        cyc(1, 0, 0, 0, 1, 32'h10, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("miss_iaddr", iaddr_a, 32'h10);

        // Redirect out of HOLD drops the parked word and aligns the target.
        cyc(1, 1, 32'hBAD0_0001, 1, 0, 0, 0);
        cyc(1, 1, 32'hBAD0_0002, 1, 1, 32'h103, 0);
        cyc(1, 1, 32'h1234_5678, 0, 0, 0, 0);
        check("redir_instr", instr_a, 32'h1234_5678);

        // Halt beats redirect, then the unit stays frozen.
        cyc(1, 0, 0, 0, 1, 32'h20, 0);
        cyc(1, 1, 32'h5555_5555, 0, 1, 32'h80, 1);
        for (int k = 0; k < 10; k++)
            cyc(1, 1, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0);
        check("halt_iaddr", iaddr_a, 32'h20);

        // Narrow counter wraps after 17 deliveries; top-of-memory PC wraps.
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) cyc(1, 1, $urandom, 0, 0, 0, 0);
        @(posedge CLK); #1;
        check("wrap_count_b", {28'b0, cnt_b}, 32'd1);

        // Reset while an instruction is parked.
        cyc(1, 1, 32'hCAFE_0000, 1, 0, 0, 0);
        cyc(0, 1, 32'hCAFE_0001, 1, 0, 0, 0);
        check("rst_iaddr_b", iaddr_b, 32'hFFFF_FFFC);
        cyc(1, 1, 32'hCAFE_0002, 0, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            bit rst_bit, hl_bit;
            rst_bit = ($urandom_range(0, 149) != 0);
            hl_bit  = !m_halted[0] && ($urandom_range(0, 199) == 0);
            cyc(rst_bit, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0, $urandom, hl_bit);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
